// File: rtl/demux4_dispatch_ctrl.sv
// 1-to-4 valid/ready dispatcher: each accepted word is held and steered to one lane, chosen by tag or round-robin.
// Define DEMUX4_DLV_CNT_EN to add per-lane delivery counters on dlv_cnt (otherwise dlv_cnt is tied to zero).
module demux4_dispatch_ctrl #(
    parameter int DATA_W      = 8,
    parameter int STALL_LIMIT = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [1:0]           in_dest,
    input  logic                 mode,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [1:0]           sel,
    output logic                 busy,
    output logic                 skip,
    output logic [4*CNT_W-1:0]   dlv_cnt
);

    // Stall counter is wide enough to reach STALL_LIMIT and saturates at all-ones.
    localparam int              SC_W       = $clog2(STALL_LIMIT + 2);
    localparam logic [SC_W-1:0] STALL_LAST = SC_W'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);
    localparam logic [SC_W-1:0] STALL_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_data;
    logic               r_mode;
    logic [1:0]         r_sel;
    logic [1:0]         r_rr_ptr;
    logic [SC_W-1:0]    r_stall_cnt;

    logic               w_hold;
    logic               w_accept;
    logic               w_deliver;
    logic               w_retarget;

    assign w_hold    = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = w_hold && out_ready[r_sel];

    // Retarget only when the held round-robin word is still blocked on the last allowed stall cycle.
    assign w_retarget = w_hold && !out_ready[r_sel] && r_mode && (STALL_LIMIT != 0)
                        && (r_stall_cnt == STALL_LAST);

    assign in_ready  = (r_state == IDLE) && !rst;
    assign busy      = w_hold;
    assign out_valid = w_hold ? (4'b0001 << r_sel) : 4'b0000;
    assign out_data  = r_data;
    assign sel       = r_sel;
    assign skip      = w_retarget;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            // NOTE: the data register is reset too, so a word discarded by reset can never reappear on out_data.
            r_data      <= '0;
            r_mode      <= 1'b0;
            r_sel       <= 2'd0;
            r_rr_ptr    <= 2'd0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data      <= in_data;
                        r_mode      <= mode;
                        r_sel       <= mode ? r_rr_ptr : in_dest;
                        r_stall_cnt <= '0;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_deliver) begin
                        r_state <= IDLE;
                        if (r_mode) r_rr_ptr <= r_sel + 2'd1;
                    end else if (w_retarget) begin
                        r_sel       <= r_sel + 2'd1;
                        r_stall_cnt <= '0;
                    end else if (r_stall_cnt != STALL_MAX) begin
                        r_stall_cnt <= r_stall_cnt + SC_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DEMUX4_DLV_CNT_EN
    logic [CNT_W-1:0] r_dlv_cnt [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_dlv_cnt[i] <= '0;
        end else if (w_deliver) begin
            r_dlv_cnt[r_sel] <= r_dlv_cnt[r_sel] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dlv_cnt
        assign dlv_cnt[g*CNT_W +: CNT_W] = r_dlv_cnt[g];
    end
`else
    assign dlv_cnt = '0;
`endif

    // Lane valid is one-hot or idle, and a held word stays put until it leaves.
    a_onehot_valid: assert property (@(posedge clk) disable iff (rst) $onehot0(out_valid));
    a_hold_stable:  assert property (@(posedge clk) disable iff (rst)
                        (w_hold && !w_deliver) |=> (r_state == HOLD && $stable(r_data)));

endmodule
